// File: rtl/nco_pkg.sv
// Shared types and default widths for the NCO frequency-sweep sequencer.
package nco_pkg;

  localparam int unsigned FCW_W_DFLT = 32;
  localparam int unsigned CNT_W_DFLT = 16;

  typedef enum logic [1:0] {
    StIdle,
    StDwell,
    StDone
  } sweep_state_e;

endpackage

// File: rtl/nco_dwell_timer.sv
// Dwell counter: counts 0..hold-1 and flags the last cycle of each FCW hold period.
// A hold of 0 is treated as 1, so o_tc is then asserted every cycle.
module nco_dwell_timer
  import nco_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DFLT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_hold,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_hold;

  assign w_hold = (i_hold == '0) ? CNT_W'(1) : i_hold;
  assign o_tc   = (r_cnt == w_hold - CNT_W'(1));

  // Wraps on terminal count so back-to-back hold periods need no extra clear.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// NCO frequency-sweep sequencer: steps the FCW from a start value, holding each value for a dwell.
// Define SWEEP_BIDIR_EN for a triangle (up then back down) sweep; default is up-sweep only.
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int unsigned FCW_W = FCW_W_DFLT,
  parameter int unsigned CNT_W = CNT_W_DFLT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [FCW_W-1:0] i_fcw_start,
  input  logic [FCW_W-1:0] i_fcw_step,
  input  logic [CNT_W-1:0] i_step_count,
  input  logic [CNT_W-1:0] i_dwell,
  output logic [FCW_W-1:0] o_fcw_out,
  output logic             o_fcw_valid,
  output logic             o_phase_clr,
  output logic             o_busy,
  output logic             o_done
);

  sweep_state_e     r_state, w_state_nxt;
  logic [FCW_W-1:0] r_fcw, w_fcw_nxt, w_fcw_stepped;
  logic [FCW_W-1:0] r_step;
  logic [CNT_W-1:0] r_dwell;
  logic [CNT_W-1:0] r_steps_left, w_steps_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_clr, w_clr_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             w_load;
  logic             w_tc;
  logic             w_tmr_clr;

`ifdef SWEEP_BIDIR_EN
  logic             r_dir_down, w_dir_nxt;
  logic [CNT_W-1:0] r_step_count;

  assign w_fcw_stepped = r_dir_down ? (r_fcw - r_step) : (r_fcw + r_step);
`else
  assign w_fcw_stepped = r_fcw + r_step;
`endif

  // Timer only runs while dwelling; it is zero on the first DWELL cycle.
  assign w_tmr_clr = (r_state != StDwell);

  nco_dwell_timer #(
    .CNT_W(CNT_W)
  ) u_dwell_timer (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (w_tmr_clr),
    .i_hold (r_dwell),
    .o_tc   (w_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_fcw_nxt   = r_fcw;
    w_steps_nxt = r_steps_left;
    w_valid_nxt = 1'b0;
    w_clr_nxt   = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
`ifdef SWEEP_BIDIR_EN
    w_dir_nxt   = r_dir_down;
`endif
    unique case (r_state)
      StIdle: begin
        if (i_start && !i_abort) begin
          w_load      = 1'b1;
          w_state_nxt = StDwell;
          w_fcw_nxt   = i_fcw_start;
          w_steps_nxt = i_step_count;
          w_valid_nxt = 1'b1;
          w_clr_nxt   = 1'b1;
          w_busy_nxt  = 1'b1;
`ifdef SWEEP_BIDIR_EN
          w_dir_nxt   = 1'b0;
`endif
        end
      end
      StDwell: begin
        if (i_abort) begin
          w_state_nxt = StIdle;
        end else begin
          w_busy_nxt = 1'b1;
          if (w_tc) begin
            if (r_steps_left != '0) begin
              w_fcw_nxt   = w_fcw_stepped;
              w_steps_nxt = r_steps_left - CNT_W'(1);
              w_valid_nxt = 1'b1;
`ifdef SWEEP_BIDIR_EN
            end else if (!r_dir_down && (r_step_count != '0)) begin
              // Turn around at the peak: first down step happens here.
              w_dir_nxt   = 1'b1;
              w_fcw_nxt   = r_fcw - r_step;
              w_steps_nxt = r_step_count - CNT_W'(1);
              w_valid_nxt = 1'b1;
`endif
            end else begin
              w_state_nxt = StDone;
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
            end
          end
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_fcw        <= '0;
      r_step       <= '0;
      r_dwell      <= '0;
      r_steps_left <= '0;
      r_valid      <= 1'b0;
      r_clr        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_fcw        <= w_fcw_nxt;
      r_steps_left <= w_steps_nxt;
      r_valid      <= w_valid_nxt;
      r_clr        <= w_clr_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      if (w_load) begin
        r_step  <= i_fcw_step;
        r_dwell <= i_dwell;
      end
    end
  end

`ifdef SWEEP_BIDIR_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_dir_down   <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_dir_down <= w_dir_nxt;
      if (w_load) begin
        r_step_count <= i_step_count;
      end
    end
  end
`endif

  assign o_fcw_out   = r_fcw;
  assign o_fcw_valid = r_valid;
  assign o_phase_clr = r_clr;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Scoreboard bench for nco_sweep_ctrl: expected FCW/done events are queued at stimulus time
// and a negedge monitor pops and compares them whenever the DUT pulses fcw_valid or done.
module tb_nco_sweep_ctrl;

  typedef struct {
    bit          is_done;
    logic [31:0] fcw;
    bit          clr;
    int          cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] fcw_start = '0;
  logic [31:0] fcw_step = '0;
  logic [15:0] step_count = '0;
  logic [15:0] dwell = '0;
  logic [31:0] fcw_out;
  logic        fcw_valid, phase_clr, busy, done;

  int  cyc = 0;
  int  n_chk = 0;
  int  n_pass = 0;
  ev_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nco_sweep_ctrl #(
    .FCW_W(32),
    .CNT_W(16)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_abort     (abort),
    .i_fcw_start (fcw_start),
    .i_fcw_step  (fcw_step),
    .i_step_count(step_count),
    .i_dwell     (dwell),
    .o_fcw_out   (fcw_out),
    .o_fcw_valid (fcw_valid),
    .o_phase_clr (phase_clr),
    .o_busy      (busy),
    .o_done      (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every output event must match the head of the scoreboard queue.
  always @(negedge clk) begin
    if (fcw_valid || done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_event", 32'({fcw_valid, done}), 32'(0));
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("event_kind", 32'(done), 32'(e.is_done));
        chk("event_cycle", 32'(cyc), 32'(e.cyc));
        chk("fcw_out", fcw_out, e.fcw);
        chk("phase_clr", 32'(phase_clr), 32'(e.clr));
        chk("busy", 32'(busy), 32'(!e.is_done));
      end
    end else if (phase_clr) begin
      chk("stray_phase_clr", 32'(phase_clr), 32'(0));
    end
  end

  // mode 0: full sweep, 1: abort at offset, 2: reset at offset (offset from first FCW cycle).
  task automatic run_sweep(input logic [31:0] fs, input logic [31:0] st, input logic [15:0] sc,
                           input logic [15:0] dw, input int mode, input int off_req);
    logic [31:0] vals[$];
    logic [31:0] acc, last;
    int          hold, n, base, cut;
    bit          hit;
    ev_t         e;
    hold = (dw == 0) ? 1 : int'(dw);
    acc  = fs;
    vals.push_back(acc);
    for (int k = 0; k < int'(sc); k++) begin
      acc = acc + st;
      vals.push_back(acc);
    end
`ifdef SWEEP_BIDIR_EN
    for (int k = 0; k < int'(sc); k++) begin
      acc = acc - st;
      vals.push_back(acc);
    end
`endif
    n = vals.size();
    @(negedge clk);
    start = 1'b1; abort = 1'b0;
    fcw_start = fs; fcw_step = st; step_count = sc; dwell = dw;
    base = cyc + 1;
    cut  = (mode == 0) ? base + n * hold + 100000 : base + (off_req % (n * hold));
    last = fs;
    foreach (vals[j]) begin
      if (base + j * hold <= cut) begin
        e = '{is_done: 1'b0, fcw: vals[j], clr: (j == 0), cyc: base + j * hold};
        exp_q.push_back(e);
        last = vals[j];
      end
    end
    if (base + n * hold <= cut) begin
      e = '{is_done: 1'b1, fcw: last, clr: 1'b0, cyc: base + n * hold};
      exp_q.push_back(e);
    end
    hit = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      if (mode == 0 && exp_q.size() == 0) begin
        hit = 1'b1;
        break;
      end
      if (mode != 0 && cyc == cut) begin
        if (mode == 1) abort = 1'b1;
        else rst_n = 1'b0;
        start = 1'b0;
        hit = 1'b1;
        break;
      end
      // Mid-sweep start and parameter churn must be ignored.
      start = 1'($urandom_range(0, 1));
      fcw_start = $urandom; fcw_step = $urandom;
      step_count = 16'($urandom); dwell = 16'($urandom);
    end
    start = 1'b0;
    chk("sweep_bound", 32'(hit), 32'(1));
    if (mode == 1) begin
      @(negedge clk); #1;
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_fcw_hold", fcw_out, last);
      chk("abort_no_done", 32'(done), 32'(0));
    end else if (mode == 2) begin
      @(negedge clk); #1;
      chk("rst_fcw", fcw_out, 32'(0));
      chk("rst_outs", 32'({fcw_valid, phase_clr, busy, done}), 32'(0));
      rst_n = 1'b1;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    exp_q.delete();
  endtask

  initial begin
    int r, mode;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_fcw", fcw_out, 32'(0));
    chk("reset_outs", 32'({fcw_valid, phase_clr, busy, done}), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_sweep(32'h0001_0000, 32'h0001_0000, 16'd3, 16'd2, 0, 0);   // basic
    run_sweep(32'hFFFF_0000, 32'h0002_0000, 16'd1, 16'd1, 0, 0);   // wrap-around
    run_sweep(32'h1234_5678, 32'h0000_1000, 16'd2, 16'd0, 0, 0);   // dwell 0
    run_sweep(32'h0000_0100, 32'h0000_0010, 16'd0, 16'd3, 0, 0);   // single value
    run_sweep(32'h0001_0000, 32'h0001_0000, 16'd10, 16'd4, 1, 5);  // abort
    run_sweep(32'h0002_0000, 32'h0000_8000, 16'd5, 16'd2, 2, 4);   // reset mid-sweep
    run_sweep(32'h0003_0000, 32'hFFFF_0000, 16'd3, 16'd1, 0, 0);   // after reset, down step

    for (int t = 0; t < 30; t++) begin
      r = int'($urandom_range(0, 9));
      mode = (r < 6) ? 0 : (r < 8) ? 1 : 2;
      run_sweep($urandom, $urandom, 16'($urandom_range(0, 5)), 16'($urandom_range(0, 4)),
                mode, int'($urandom_range(0, 1000)));
    end

    repeat (5) @(negedge clk);
    #1;
    chk("final_idle_busy", 32'(busy), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Frequency-sweep sequencer for the NCO. It programs the 32-bit frequency control word (FCW) that feeds the phase accumulator, whose output passes through Quantizer32to16 to the phase LUT. After a start request it steps the FCW from a start value by a signed-agnostic (modulo 2^32) increment, holding each value for a programmable dwell, and signals completion. It also clears the accumulator phase at sweep start.

## Interface
Parameters:
- FCW_W, 32, FCW and step width
- CNT_W, 16, width of step_count and dwell

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-low
- start  in  1  sweep request, sampled only in IDLE
- abort  in  1  terminate sweep, returns to IDLE
- fcw_start  in  FCW_W  first FCW of sweep
- fcw_step  in  FCW_W  increment added per step, mod 2^FCW_W
- step_count  in  CNT_W  number of increments after the first value
- dwell  in  CNT_W  cycles each FCW is held; 0 is treated as 1
- fcw_out  out  FCW_W  FCW to phase accumulator
- fcw_valid  out  1  one-cycle pulse whenever fcw_out takes a new value
- phase_clr  out  1  one-cycle pulse, accumulator clear
- busy  out  1  high in LOAD-free run states (DWELL)
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, DWELL, DONE.
- IDLE: busy=0. If start=1 and abort=0, latch fcw_step, step_count, and hold=max(dwell,1) into internal registers. Next cycle: state DWELL, fcw_out=fcw_start, fcw_valid=1, phase_clr=1, busy=1, dwell counter=0, steps_left=step_count.
- DWELL: counter increments each cycle. When counter==hold-1:
  - If steps_left>0: fcw_out+=step, wrapping mod 2^32. steps_left decrements. fcw_valid pulses the next cycle, and the counter clears.
  - If steps_left==0: go to DONE.
- DONE: done=1 and busy=0 for one cycle, then return to IDLE. fcw_out keeps its last value.
- abort=1 in DWELL or DONE: the next state is IDLE. done is not asserted and fcw_out holds its value. abort has priority over start and over step events.
- start while busy is ignored. Input changes during a sweep have no effect, because all parameters are latched.
- Reset (rst=0, at any time, including mid-sweep): state=IDLE and fcw_out=0. fcw_valid, phase_clr, busy and done are all 0.

## Timing
- Start sampled at edge T. First fcw_valid, phase_clr and busy appear at cycle T+1.
- Each FCW value is held for exactly hold cycles.
- Unidirectional sweep: the final value appears at T+1+step_count·hold, and done pulses at T+1+(step_count+1)·hold.
- step_count=0: a single value is held for hold cycles, then done.
- A new start is accepted no earlier than the cycle after done, while the block is in IDLE.
- All outputs are registered, with no combinational input-to-output paths.

## Configuration
- SWEEP_BIDIR_EN defined: triangle sweep.
  - After the up-leg reaches its last value, the block subtracts fcw_step for step_count further steps, back down to fcw_start.
  - Each step pulses fcw_valid.
  - done pulses at T+1+(2·step_count+1)·hold.
  - step_count=0 behaves exactly as in the unidirectional build.
  - Adds an UP/DOWN direction register inside DWELL.
- Not defined: unidirectional up-sweep only, with no direction logic.

## Structure
- Shared package nco_pkg holds:
  - FCW_W and CNT_W defaults
  - the sweep state enum (IDLE, DWELL, DONE)
- Sub-module nco_dwell_timer holds the hold counter, clear/terminal-count logic, and the dwell=0→1 mapping. Its inputs are clk, rst, clr and hold; its output is tc.
- The top level holds the FSM, FCW adder, step counter and direction register.

## Test plan
- Basic sweep: fcw_start=0x00010000, fcw_step=0x00010000, step_count=3, dwell=2, start at T.
  - fcw_out is 0x10000, 0x20000, 0x30000, 0x40000, each for 2 cycles, from T+1.
  - fcw_valid pulses 4 times, and done pulses at T+9.
  - Quantized values seen downstream: 1, 2, 3, 4.
- Wrap-around: fcw_start=0xFFFF0000, step=0x00020000, step_count=1, dwell=1.
  - fcw_out is 0xFFFF0000 at T+1, then 0x00010000 at T+2.
  - done pulses at T+3.
- dwell=0 with step_count=2: behaves identically to dwell=1, and done pulses at T+4.
- Abort and busy start: start a 10-step sweep with dwell=4, then assert abort at T+6.
  - At T+7 the state is IDLE, busy=0, fcw_out holds, and no done is seen.
  - A start asserted at T+3, during the sweep, is ignored.
- Reset mid-sweep: rst=0 at T+5.
  - At the next edge every output is 0 and the state is IDLE.
  - A start issued after reset release runs a full correct sweep.
- SWEEP_BIDIR_EN build, with fcw_start=0x10000, step=0x10000, step_count=2, dwell=1:
  - fcw_out sequence is 1,2,3,2,1 (×0x10000).
  - done pulses at T+6.
